// File: rtl/pic14_exec_core.sv
`default_nettype none
// ============================================================================
// Module      : pic14_exec_core
// Description : Single-clock execute core for a PIC16-style 14-bit ISA.
//               Holds PC, circular return stack, W and Z/C/DC flags; decodes
//               and executes one instruction per clock against an external
//               instruction memory and file-register array.
//               Optional macro PIC14_STACK_STATUS_EN adds sticky stack
//               overflow/underflow outputs backed by an occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pic14_exec_core #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [13:0]     instr,
  input  logic [7:0]      f_rdata,
  output logic [PC_W-1:0] pc,
  output logic [6:0]      f_addr,
  output logic [7:0]      f_wdata,
  output logic            f_we,
  output logic [7:0]      w,
  output logic            zero,
  output logic            carry,
`ifdef PIC14_STACK_STATUS_EN
  output logic            dcarry,
  output logic            stk_ovf,
  output logic            stk_unf
`else
  output logic            dcarry
`endif
);

  localparam int c_SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Architectural state
  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_w;
  logic              r_z;
  logic              r_c;
  logic              r_dc;
  logic              r_skip;
  logic [c_SP_W-1:0] r_sp;
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  // Instruction fields
  logic [1:0]  w_cls;
  logic [3:0]  w_op;
  logic        w_d;
  logic [2:0]  w_bit;
  logic [7:0]  w_k;
  logic [7:0]  w_mask;

  // Shared adder for ADDWF/SUBWF/ADDLW/SUBLW; subtraction is a + ~w + 1 so
  // carry out directly reads as "no borrow".
  logic        w_sub;
  logic [7:0]  w_add_lhs;
  logic [7:0]  w_add_rhs;
  logic [8:0]  w_sum;
  logic [4:0]  w_nib;

  // Decoder outputs
  logic [7:0]      w_res;
  logic            w_we_f;
  logic            w_we_w;
  logic            w_wr_d;
  logic            w_upd_z;
  logic            w_upd_c;
  logic            w_upd_dc;
  logic            w_c_val;
  logic            w_dc_val;
  logic            w_skip_cond;
  logic            w_push;
  logic            w_pop;
  logic            w_jump;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic [c_SP_W-1:0] w_sp_dec;

  assign w_cls  = instr[13:12];
  assign w_op   = instr[11:8];
  assign w_d    = instr[7];
  assign w_bit  = instr[9:7];
  assign w_k    = instr[7:0];
  assign w_mask = 8'h01 << w_bit;

  assign w_sub     = ((w_cls == 2'b00) && (w_op == 4'b0010)) ||
                     ((w_cls == 2'b11) && (w_op[3:1] == 3'b110));
  assign w_add_lhs = (w_cls == 2'b11) ? w_k : f_rdata;
  assign w_add_rhs = w_sub ? ~r_w : r_w;
  assign w_sum     = {1'b0, w_add_lhs} + {1'b0, w_add_rhs} + {8'd0, w_sub};
  assign w_nib     = {1'b0, w_add_lhs[3:0]} + {1'b0, w_add_rhs[3:0]} + {4'd0, w_sub};

  assign w_pc_inc = r_pc + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;

  // Instruction decode and ALU result selection
  always_comb begin
    w_res       = f_rdata;
    w_we_f      = 1'b0;
    w_we_w      = 1'b0;
    w_wr_d      = 1'b0;
    w_upd_z     = 1'b0;
    w_upd_c     = 1'b0;
    w_upd_dc    = 1'b0;
    w_c_val     = w_sum[8];
    w_dc_val    = w_nib[4];
    w_skip_cond = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_jump      = 1'b0;

    case (w_cls)
      2'b00: begin
        // Every byte op except the 0000 group routes its result by d.
        w_wr_d = (w_op != 4'b0000);
        case (w_op)
          4'b0000: begin
            if (w_d) begin
              w_res  = r_w;
              w_we_f = 1'b1;
            end else if (instr == 14'h0008) begin
              w_pop = 1'b1;
            end
          end
          4'b0001: begin w_res = 8'h00;             w_upd_z = 1'b1; end
          4'b0010: begin w_res = w_sum[7:0];        w_upd_z = 1'b1; w_upd_c = 1'b1; w_upd_dc = 1'b1; end
          4'b0011: begin w_res = f_rdata - 8'd1;    w_upd_z = 1'b1; end
          4'b0100: begin w_res = f_rdata | r_w;     w_upd_z = 1'b1; end
          4'b0101: begin w_res = f_rdata & r_w;     w_upd_z = 1'b1; end
          4'b0110: begin w_res = f_rdata ^ r_w;     w_upd_z = 1'b1; end
          4'b0111: begin w_res = w_sum[7:0];        w_upd_z = 1'b1; w_upd_c = 1'b1; w_upd_dc = 1'b1; end
          4'b1000: begin w_res = f_rdata;           w_upd_z = 1'b1; end
          4'b1001: begin w_res = ~f_rdata;          w_upd_z = 1'b1; end
          4'b1010: begin w_res = f_rdata + 8'd1;    w_upd_z = 1'b1; end
          4'b1011: begin
            w_res       = f_rdata - 8'd1;
            w_skip_cond = (w_res == 8'h00);
          end
          4'b1100: begin
            w_res   = {r_c, f_rdata[7:1]};
            w_upd_c = 1'b1;
            w_c_val = f_rdata[0];
          end
          4'b1101: begin
            w_res   = {f_rdata[6:0], r_c};
            w_upd_c = 1'b1;
            w_c_val = f_rdata[7];
          end
          4'b1110: begin w_res = {f_rdata[3:0], f_rdata[7:4]}; end
          default: begin
            w_res       = f_rdata + 8'd1;
            w_skip_cond = (w_res == 8'h00);
          end
        endcase
        if (w_wr_d) begin
          w_we_f = w_d;
          w_we_w = ~w_d;
        end
      end
      2'b01: begin
        case (instr[11:10])
          2'b00:   begin w_res = f_rdata & ~w_mask; w_we_f = 1'b1; end
          2'b01:   begin w_res = f_rdata | w_mask;  w_we_f = 1'b1; end
          2'b10:   w_skip_cond = ((f_rdata & w_mask) == 8'h00);
          default: w_skip_cond = ((f_rdata & w_mask) != 8'h00);
        endcase
      end
      2'b10: begin
        w_jump = 1'b1;
        w_push = ~instr[11];
      end
      default: begin
        casez (w_op)
          4'b00??: begin w_res = w_k; w_we_w = 1'b1; end
          4'b01??: begin w_res = w_k; w_we_w = 1'b1; w_pop = 1'b1; end
          4'b1000: begin w_res = w_k | r_w; w_we_w = 1'b1; w_upd_z = 1'b1; end
          4'b1001: begin w_res = w_k & r_w; w_we_w = 1'b1; w_upd_z = 1'b1; end
          4'b1010: begin w_res = w_k ^ r_w; w_we_w = 1'b1; w_upd_z = 1'b1; end
          4'b110?,
          4'b111?: begin
            w_res    = w_sum[7:0];
            w_we_w   = 1'b1;
            w_upd_z  = 1'b1;
            w_upd_c  = 1'b1;
            w_upd_dc = 1'b1;
          end
          default: w_res = f_rdata;
        endcase
      end
    endcase
  end

  // Next-PC selection: return pops the entry below the stack pointer
  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_pop) begin
      w_pc_next = r_stack[w_sp_dec];
    end else if (w_jump) begin
      w_pc_next = {{(PC_W-11){1'b0}}, instr[10:0]};
    end
  end

  // PC, W, flags, stack pointer and skip state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_w    <= 8'h00;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_dc   <= 1'b0;
      r_sp   <= '0;
      r_skip <= 1'b0;
    end else if (r_skip) begin
      r_pc   <= w_pc_inc;
      r_skip <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_skip <= w_skip_cond;
      if (w_we_w)   r_w  <= w_res;
      if (w_upd_z)  r_z  <= (w_res == 8'h00);
      if (w_upd_c)  r_c  <= w_c_val;
      if (w_upd_dc) r_dc <= w_dc_val;
      if (w_push)      r_sp <= r_sp + 1'b1;
      else if (w_pop)  r_sp <= w_sp_dec;
    end
  end

  // Return-stack storage; wrapping the pointer overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (!r_skip && w_push) begin
      r_stack[r_sp] <= w_pc_inc;
    end
  end

`ifdef PIC14_STACK_STATUS_EN
  localparam logic [c_SP_W:0] c_FULL = (c_SP_W+1)'(STACK_DEPTH);

  logic [c_SP_W:0] r_cnt;
  logic            r_ovf;
  logic            r_unf;

  // Occupancy tracking with sticky overflow/underflow flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!r_skip) begin
      if (w_push) begin
        if (r_cnt == c_FULL) r_ovf <= 1'b1;
        else                 r_cnt <= r_cnt + 1'b1;
      end else if (w_pop) begin
        if (r_cnt == '0) r_unf <= 1'b1;
        else             r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;
`endif

  assign pc      = r_pc;
  assign f_addr  = instr[6:0];
  assign f_wdata = w_res;
  assign f_we    = w_we_f & ~r_skip;
  assign w       = r_w;
  assign zero    = r_z;
  assign carry   = r_c;
  assign dcarry  = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_pic14_exec_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic14_exec_core
// Description : Self-checking bench for pic14_exec_core. Expected PC/W/flag
//               state is queued when each instruction is driven and compared
//               after the executing clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic14_exec_core;

  logic        clk;
  logic        reset;
  logic [13:0] instr;
  logic [7:0]  f_rdata;
  logic [12:0] pc;
  logic [6:0]  f_addr;
  logic [7:0]  f_wdata;
  logic        f_we;
  logic [7:0]  w;
  logic        zero;
  logic        carry;
  logic        dcarry;
`ifdef PIC14_STACK_STATUS_EN
  logic        stk_ovf;
  logic        stk_unf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [12:0] pc;
    logic [7:0]  w;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb_q[$];

  pic14_exec_core dut (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .f_rdata (f_rdata),
    .pc      (pc),
    .f_addr  (f_addr),
    .f_wdata (f_wdata),
    .f_we    (f_we),
    .w       (w),
    .zero    (zero),
    .carry   (carry),
`ifdef PIC14_STACK_STATUS_EN
    .dcarry  (dcarry),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
`else
    .dcarry  (dcarry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction, check the comb file-write outputs, queue the
  // expected post-edge state, then pop and compare after the edge.
  task automatic step(input string tag, input logic [13:0] ins, input logic [7:0] frd,
                      input logic exp_we, input logic [7:0] exp_wd,
                      input logic [12:0] exp_pc, input logic [7:0] exp_w,
                      input logic [2:0] exp_flg);
    exp_t e;
    @(negedge clk);
    instr   = ins;
    f_rdata = frd;
    reset   = 1'b0;
    #1;
    chk({tag, ".we"}, 16'(f_we), 16'(exp_we));
    if (exp_we) chk({tag, ".wdata"}, 16'(f_wdata), 16'(exp_wd));
    e.tag = tag; e.pc = exp_pc; e.w = exp_w; e.flg = exp_flg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".pc"},  16'(pc), 16'(e.pc));
    chk({e.tag, ".w"},   16'(w),  16'(e.w));
    chk({e.tag, ".zcd"}, 16'({zero, carry, dcarry}), 16'(e.flg));
  endtask

  logic [12:0] ret_pc [9];
  logic [12:0] cur_pc;
  logic [12:0] tgt;

  initial begin
    reset   = 1'b1;
    instr   = 14'h0000;
    f_rdata = 8'h00;
    #23;
    chk("rst.pc",  16'(pc), 16'h0000);
    chk("rst.w",   16'(w),  16'h0000);
    chk("rst.zcd", 16'({zero, carry, dcarry}), 16'h0000);

    //   tag        instr     f_rd   we    wdata  pc        w      zcd
    step("movlw",   14'h3005, 8'h00, 1'b0, 8'h00, 13'h001, 8'h05, 3'b000);
    step("addlw",   14'h3EFB, 8'h00, 1'b0, 8'h00, 13'h002, 8'h00, 3'b111);
    step("call",    14'h2010, 8'h00, 1'b0, 8'h00, 13'h010, 8'h00, 3'b111);
    step("return",  14'h0008, 8'h00, 1'b0, 8'h00, 13'h003, 8'h00, 3'b111);
    step("decfsz",  14'h0BA0, 8'h01, 1'b1, 8'h00, 13'h004, 8'h00, 3'b111);
    step("squash1", 14'h3077, 8'h00, 1'b0, 8'h00, 13'h005, 8'h00, 3'b111);
    step("bsf",     14'h1420, 8'h00, 1'b1, 8'h01, 13'h006, 8'h00, 3'b111);
    step("sublw",   14'h3C10, 8'h00, 1'b0, 8'h00, 13'h007, 8'h10, 3'b011);
    step("subwf",   14'h0220, 8'h05, 1'b0, 8'h00, 13'h008, 8'hF5, 3'b001);
    step("rlf",     14'h0DA0, 8'h81, 1'b1, 8'h02, 13'h009, 8'hF5, 3'b011);
    step("movwf",   14'h00A0, 8'h00, 1'b1, 8'hF5, 13'h00A, 8'hF5, 3'b011);
    step("btfss",   14'h1C20, 8'h01, 1'b0, 8'h00, 13'h00B, 8'hF5, 3'b011);
    step("squash2", 14'h1820, 8'h00, 1'b0, 8'h00, 13'h00C, 8'hF5, 3'b011);
    step("xorlw",   14'h3A0F, 8'h00, 1'b0, 8'h00, 13'h00D, 8'hFA, 3'b011);
    step("clrf",    14'h0180, 8'h5A, 1'b1, 8'h00, 13'h00E, 8'hFA, 3'b111);
    step("goto",    14'h2FFF, 8'h00, 1'b0, 8'h00, 13'h7FF, 8'hFA, 3'b111);
    step("swapf",   14'h0E20, 8'h3C, 1'b0, 8'h00, 13'h800, 8'hC3, 3'b111);

    // Nine nested calls: the ninth wraps and overwrites the oldest slot.
    cur_pc = 13'h800;
    for (int i = 0; i < 9; i++) begin
      tgt       = 13'h100 + 13'(i * 16);
      ret_pc[i] = cur_pc + 13'd1;
      step($sformatf("ncall%0d", i), 14'h2000 | 14'(tgt), 8'h00, 1'b0, 8'h00,
           tgt, 8'hC3, 3'b111);
      cur_pc = tgt;
`ifdef PIC14_STACK_STATUS_EN
      chk($sformatf("ovf%0d", i), 16'(stk_ovf), (i == 8) ? 16'h1 : 16'h0);
`endif
    end

    // Returns come back in LIFO order; the ninth sees the overwritten slot,
    // which now holds the newest return address.
    for (int j = 0; j < 9; j++) begin
      tgt = (j == 8) ? ret_pc[8] : ret_pc[8 - j];
      step($sformatf("nret%0d", j), 14'h0008, 8'h00, 1'b0, 8'h00, tgt, 8'hC3, 3'b111);
`ifdef PIC14_STACK_STATUS_EN
      chk($sformatf("ovfhold%0d", j), 16'(stk_ovf), 16'h1);
      chk($sformatf("unf%0d", j), 16'(stk_unf), (j == 8) ? 16'h1 : 16'h0);
`endif
    end

    // Asynchronous reset in the middle of a cycle discards the instruction.
    @(negedge clk);
    instr = 14'h3055;
    #2 reset = 1'b1;
    #1;
    chk("areset.pc",  16'(pc), 16'h0000);
    chk("areset.w",   16'(w),  16'h0000);
    chk("areset.zcd", 16'({zero, carry, dcarry}), 16'h0000);
    @(posedge clk);
    #1;
    chk("areset.hold.pc", 16'(pc), 16'h0000);
    chk("areset.hold.w",  16'(w),  16'h0000);
`ifdef PIC14_STACK_STATUS_EN
    chk("areset.ovf", 16'(stk_ovf), 16'h0);
    chk("areset.unf", 16'(stk_unf), 16'h0);
`endif
    chk("sb.empty", 16'(sb_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
